// File: rtl/dpi_call_responder.sv
// Call responder: one accept-stage register feeding a 2-entry in-order response FIFO.
// Each accepted call is evaluated from the S1 register and the result is written into the FIFO.
module dpi_call_responder #(
    parameter int INST   = 1,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_func,
    input  logic [6:0]        req_width,
    input  logic [DATA_W-1:0] req_arg,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        rsp_func,
    output logic              rsp_err,
    output logic [15:0]       calls_done
);

    typedef struct packed {
        logic [3:0]        func;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic              s1_valid;
    logic [3:0]        s1_func;
    logic [6:0]        s1_width;
    logic [DATA_W-1:0] s1_arg;
    rsp_t              s1_rsp;

    rsp_t              fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;
    logic [1:0]        occupancy;
    logic              ready_en;
    logic              accept;
    logic              retire;
    rsp_t              head;

    function automatic rsp_t compute(input logic [3:0]        func,
                                     input logic [6:0]        width,
                                     input logic [DATA_W-1:0] arg);
        rsp_t              r;
        logic [127:0]      a;
        logic [DATA_W-1:0] mask;
        logic [31:0]       r32;
        logic [7:0]        nz;
        logic              width_ok;
        r        = '0;
        r.func   = func;
        a        = 128'(arg);
        r32      = '0;
        nz       = '0;
        width_ok = (width != 7'd0) && (int'(width) <= DATA_W);
        mask     = '1;
        if (width_ok)
            mask = mask >> (DATA_W - int'(width));
        case (func)
            4'd0: if (width_ok) r.data = ~arg & mask; else r.err = 1'b1;
            4'd1: if (width_ok) r.data = (arg + DATA_W'(2)) & mask; else r.err = 1'b1;
            4'd2: begin
                r32    = a[63:32] - a[31:0];
                r.data = DATA_W'(r32);
            end
            4'd3: begin
                r32    = 32'(INST) + a[31:0];
                r.data = DATA_W'(r32);
            end
            4'd4: r.data = DATA_W'(12'h123);
            4'd5: begin
                for (int i = 0; i < DATA_W / 8; i++)
                    if (arg[8*i +: 8] != 8'd0) nz = nz + 8'd1;
                r.data = DATA_W'(nz);
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    assign s1_rsp    = compute(s1_func, s1_width, s1_arg);
    assign rsp_valid = (fifo_count != 2'd0);
    assign retire    = rsp_valid && rsp_ready;
    assign occupancy = {1'b0, s1_valid} + fifo_count;
    // S1 always drains into the FIFO next edge, so occupancy never exceeds 2.
    assign req_ready = ready_en && ((occupancy < 2'd2) || ((occupancy == 2'd2) && retire));
    assign accept    = req_valid && req_ready;

    assign head      = fifo_mem[rd_ptr];
    assign rsp_data  = rsp_valid ? head.data : '0;
    assign rsp_func  = rsp_valid ? head.func : 4'd0;
    assign rsp_err   = rsp_valid ? head.err  : 1'b0;

    // NOTE: payload registers carry no reset; the valid/count flops alone decide whether they are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_func  <= req_func;
            s1_width <= req_width;
            s1_arg   <= req_arg;
        end
        if (s1_valid)
            fifo_mem[wr_ptr] <= s1_rsp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            s1_valid   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            calls_done <= 16'd0;
        end else begin
            ready_en   <= 1'b1;
            s1_valid   <= accept;
            if (s1_valid) wr_ptr <= ~wr_ptr;
            if (retire)   rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, s1_valid} - {1'b0, retire};
            if (retire && (calls_done != 16'hFFFF))
                calls_done <= calls_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_dpi_call_responder.sv
// Directed self-checking bench for dpi_call_responder (INST=2, DATA_W=96).
module tb_dpi_call_responder;

    localparam int DATA_W = 96;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_func;
    logic [6:0]        req_width;
    logic [DATA_W-1:0] req_arg;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [3:0]        rsp_func;
    logic              rsp_err;
    logic [15:0]       calls_done;

    int checks   = 0;
    int failures = 0;

    dpi_call_responder #(.INST(2), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_func   (req_func),
        .req_width  (req_width),
        .req_arg    (req_arg),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_func   (rsp_func),
        .rsp_err    (rsp_err),
        .calls_done (calls_done)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue one call and retire its response; timeouts are reported as failures.
    task automatic do_call(input logic [3:0] f, input logic [6:0] w, input logic [DATA_W-1:0] a,
                           output logic [DATA_W-1:0] d, output logic [3:0] fo, output logic e);
        int n;
        d = '0; fo = '0; e = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_func = f; req_width = w; req_arg = a; rsp_ready = 1'b0;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            checks++; failures++;
            $display("FAIL do_call_timeout func=%0d: rsp_valid never rose", f);
        end
        d = rsp_data; fo = rsp_func; e = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_func = '0; req_width = '0; req_arg = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready, rsp_err, rsp_func, calls_done} !== 23'd0 || rsp_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b ready=%b err=%b func=%0d done=%0d data=%h, required all 0",
                     rsp_valid, req_ready, rsp_err, rsp_func, calls_done, rsp_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++; $display("FAIL ready_before_edge: got %b required 0", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL ready_after_edge: got %b required 1", req_ready);
        end
    endtask

    task automatic test_inv_latency();
        @(negedge clk);
        req_valid = 1'b1; req_func = 4'd0; req_width = 7'd8; req_arg = DATA_W'(8'hA5); rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL inv_latency_early: rsp_valid=%b required 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== DATA_W'(8'h5A) || rsp_err !== 1'b0 || rsp_func !== 4'd0) begin
            failures++;
            $display("FAIL inv_a5: valid=%b data=%h err=%b func=%0d, required 1 5a 0 0",
                     rsp_valid, rsp_data, rsp_err, rsp_func);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== DATA_W'(8'h5A)) begin
            failures++; $display("FAIL inv_hold: valid=%b data=%h required 1 5a", rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || calls_done !== 16'd1) begin
            failures++; $display("FAIL inv_retire: valid=%b done=%0d required 0 1", rsp_valid, calls_done);
        end
    endtask

    task automatic test_funcs();
        logic [DATA_W-1:0] d; logic [3:0] fo; logic e;
        do_call(4'd2, 7'd0, DATA_W'(64'h054321ab_05a43b21), d, fo, e);
        checks++;
        if (d !== DATA_W'(32'hFF9EE68A) || e !== 1'b0 || fo !== 4'd2) begin
            failures++; $display("FAIL subst: data=%h err=%b func=%0d required ff9ee68a 0 2", d, e, fo);
        end
        do_call(4'd3, 7'd32, DATA_W'(5), d, fo, e);
        checks++;
        if (d !== DATA_W'(7) || e !== 1'b0) begin
            failures++; $display("FAIL inst: data=%h err=%b required 7 0", d, e);
        end
        do_call(4'd4, 7'd12, {DATA_W{1'b1}}, d, fo, e);
        checks++;
        if (d !== DATA_W'(12'h123) || e !== 1'b0) begin
            failures++; $display("FAIL const: data=%h err=%b required 123 0", d, e);
        end
        do_call(4'd5, 7'd48, DATA_W'(48'h68656C6C6F36), d, fo, e);
        checks++;
        if (d !== DATA_W'(6) || e !== 1'b0) begin
            failures++; $display("FAIL strlen_hello6: data=%h required 6", d);
        end
        do_call(4'd5, 7'd8, '0, d, fo, e);
        checks++;
        if (d !== '0 || e !== 1'b0) begin
            failures++; $display("FAIL strlen_zero: data=%h required 0", d);
        end
        do_call(4'd1, 7'd4, DATA_W'(4'hF), d, fo, e);
        checks++;
        if (d !== DATA_W'(1) || e !== 1'b0) begin
            failures++; $display("FAIL add2_w4_wrap: data=%h required 1", d);
        end
        do_call(4'd1, 7'd96, {DATA_W{1'b1}}, d, fo, e);
        checks++;
        if (d !== DATA_W'(1) || e !== 1'b0) begin
            failures++; $display("FAIL add2_w96_wrap: data=%h required 1", d);
        end
        do_call(4'd0, 7'd96, DATA_W'(0), d, fo, e);
        checks++;
        if (d !== {DATA_W{1'b1}} || e !== 1'b0) begin
            failures++; $display("FAIL inv_w96: data=%h required all ones", d);
        end
    endtask

    task automatic test_errors();
        logic [DATA_W-1:0] d; logic [3:0] fo; logic e;
        do_call(4'd9, 7'd8, DATA_W'(8'h33), d, fo, e);
        checks++;
        if (e !== 1'b1 || d !== '0 || fo !== 4'd9) begin
            failures++; $display("FAIL err_func9: err=%b data=%h func=%0d required 1 0 9", e, d, fo);
        end
        do_call(4'd0, 7'd0, DATA_W'(8'hA5), d, fo, e);
        checks++;
        if (e !== 1'b1 || d !== '0 || fo !== 4'd0) begin
            failures++; $display("FAIL err_inv_w0: err=%b data=%h func=%0d required 1 0 0", e, d, fo);
        end
        do_call(4'd1, 7'd97, DATA_W'(8'h01), d, fo, e);
        checks++;
        if (e !== 1'b1 || d !== '0 || fo !== 4'd1) begin
            failures++; $display("FAIL err_add2_w97: err=%b data=%h func=%0d required 1 0 1", e, d, fo);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req_func = 4'd3; req_width = 7'd32;
        req_valid = 1'b1; req_arg = DATA_W'(10);
        @(posedge clk);
        @(negedge clk);
        req_arg = DATA_W'(20);
        @(posedge clk);
        @(negedge clk);
        req_arg = DATA_W'(30);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_third_blocked: ready=%b required 0", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== DATA_W'(12)) begin
            failures++; $display("FAIL b2b_head_a: valid=%b data=%h required 1 c", rsp_valid, rsp_data);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_data !== DATA_W'(12)) begin
            failures++; $display("FAIL b2b_still_blocked: ready=%b data=%h required 0 c", req_ready, rsp_data);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_ready_on_retire: ready=%b required 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== DATA_W'(22)) begin
            failures++; $display("FAIL b2b_order_b: valid=%b data=%h required 1 16", rsp_valid, rsp_data);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== DATA_W'(32)) begin
            failures++; $display("FAIL b2b_order_c: valid=%b data=%h required 1 20", rsp_valid, rsp_data);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || calls_done !== 16'd3) begin
            failures++; $display("FAIL b2b_drained: valid=%b done=%0d required 0 3", rsp_valid, calls_done);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_func = 4'd4; req_width = 7'd8; req_arg = '0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || calls_done !== 16'd0) begin
            failures++;
            $display("FAIL midreset_assert: valid=%b ready=%b done=%0d required 0 0 0",
                     rsp_valid, req_ready, calls_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || calls_done !== 16'd0) begin
            failures++;
            $display("FAIL midreset_release: valid=%b ready=%b done=%0d required 0 1 0",
                     rsp_valid, req_ready, calls_done);
        end
    endtask

    initial begin
        test_reset();
        test_inv_latency();
        test_funcs();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
